// File: rtl/conv_pad_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// conv_pkg: shared encodings for the padded 3x3 convolution row sequencer.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package conv_pkg;

  localparam logic [1:0] SEL_LEFT   = 2'b00;
  localparam logic [1:0] SEL_RIGHT  = 2'b01;
  localparam logic [1:0] SEL_CENTRE = 2'b10;
  localparam logic [1:0] SEL_CLEAR  = 2'b11;

  localparam logic [1:0] ROW_TOP = 2'd0;
  localparam logic [1:0] ROW_MID = 2'd1;
  localparam logic [1:0] ROW_BOT = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    DRAIN  = 3'd2,
    VALID  = 3'd3,
    FINISH = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    TAP_L = 2'd0,
    TAP_C = 2'd1,
    TAP_R = 2'd2
  } tap_e;

  // How the source row moves across one clock edge
  typedef enum logic [2:0] {
    CMD_HOLD = 3'd0,
    CMD_INIT = 3'd1,
    CMD_INC  = 3'd2,
    CMD_DEC1 = 3'd3,
    CMD_DEC2 = 3'd4
  } row_cmd_e;

  function automatic logic [1:0] tap_sel(input tap_e t);
    logic [1:0] s;
    case (t)
      TAP_L:   s = SEL_LEFT;
      TAP_C:   s = SEL_CENTRE;
      default: s = SEL_RIGHT;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_pad_sequencer_addr_gen.sv
// ----------------------------------------------------------------------------
// conv_pad_addr_gen: source-row base tracking, tap bounds and read address.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module conv_pad_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ADDR_W = 10,
  parameter int CW     = $clog2(IMG_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  row_cmd_e          i_cmd,
  input  logic              i_issue,
  input  tap_e              i_tap,
  input  logic [CW-1:0]     i_col,
  output logic              o_row_ok,
  output logic              o_left_ok,
  output logic              o_right_ok,
  output logic [ADDR_W-1:0] o_rd_addr
);

  localparam int BW = ADDR_W + 2;
  localparam int SW = $clog2(IMG_H) + 2;
  localparam logic signed [BW-1:0] W_S    = BW'(IMG_W);
  localparam logic signed [SW-1:0] H_S    = SW'(IMG_H);
  localparam logic signed [SW-1:0] ONE_S  = SW'(1);
  localparam logic [CW-1:0]        C_LAST = CW'(IMG_W - 1);

  logic signed [BW-1:0] r_base;
  logic signed [BW-1:0] w_base_nxt;
  logic signed [SW-1:0] r_sr;
  logic signed [SW-1:0] w_sr_nxt;
  logic [ADDR_W-1:0]    w_off;
  logic [ADDR_W-1:0]    w_addr;
  logic [ADDR_W-1:0]    r_rd_addr;

  // base tracks sr*IMG_W incrementally; sr itself is kept for the bounds test
  always_comb begin
    w_base_nxt = r_base;
    w_sr_nxt   = r_sr;
    unique case (i_cmd)
      CMD_INIT: begin
        w_base_nxt = -W_S;
        w_sr_nxt   = '1;
      end
      CMD_INC: begin
        w_base_nxt = r_base + W_S;
        w_sr_nxt   = r_sr + ONE_S;
      end
      CMD_DEC1: begin
        w_base_nxt = r_base - W_S;
        w_sr_nxt   = r_sr - ONE_S;
      end
      CMD_DEC2: begin
        w_base_nxt = r_base - W_S - W_S;
        w_sr_nxt   = r_sr - ONE_S - ONE_S;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_row_ok   = !w_sr_nxt[SW-1] && (w_sr_nxt < H_S);
    o_left_ok  = (i_col != '0);
    o_right_ok = (i_col != C_LAST);
    w_off      = '0;
    if (i_tap == TAP_L) begin
      w_off = '1;
    end else if (i_tap == TAP_R) begin
      w_off = ADDR_W'(1);
    end
    // Modular narrow add: the true address is always in range when issued
    w_addr = w_base_nxt[ADDR_W-1:0] + ADDR_W'(i_col) + w_off;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base    <= '0;
      r_sr      <= '0;
      r_rd_addr <= '0;
    end else begin
      r_base <= w_base_nxt;
      r_sr   <= w_sr_nxt;
      if (i_issue) begin
        r_rd_addr <= w_addr;
      end
    end
  end

  assign o_rd_addr = r_rd_addr;

endmodule

`default_nettype wire

// File: rtl/conv_pad_sequencer.sv
// ----------------------------------------------------------------------------
// conv_pad_sequencer: raster-scans 3x3 zero-padded windows, fetching taps into
// a padded row buffer. Option macro CONV_PAD_PERF_CNT_EN adds cycle_cnt. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module conv_pad_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ADDR_W = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       rd_en,
  output logic [ADDR_W-1:0]          rd_addr,
  output logic [1:0]                 sel,
  output logic                       row_valid,
  output logic [1:0]                 row_idx,
  output logic [$clog2(IMG_H)-1:0]   out_r,
  output logic [$clog2(IMG_W)-1:0]   out_c,
  output logic                       win_last,
  output logic                       busy,
  output logic                       done
`ifdef CONV_PAD_PERF_CNT_EN
  ,
  output logic [15:0]                cycle_cnt
`endif
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  tap_e          r_tap;
  tap_e          w_tap_nxt;
  logic [RW-1:0] r_out_r;
  logic [RW-1:0] w_r_nxt;
  logic [CW-1:0] r_out_c;
  logic [CW-1:0] w_c_nxt;
  logic [1:0]    r_row_idx;
  logic [1:0]    w_ri_nxt;
  row_cmd_e      w_cmd;
  logic          w_row_start;
  logic          w_to_finish;
  logic          w_row_ok;
  logic          w_left_ok;
  logic          w_right_ok;

  logic          r_rd_en;
  logic [1:0]    r_sel;
  logic          r_row_valid;
  logic          r_win_last;
  logic          r_busy;
  logic          r_done;

  // Window/row position bookkeeping and row-base command
  always_comb begin
    w_r_nxt     = r_out_r;
    w_c_nxt     = r_out_c;
    w_ri_nxt    = r_row_idx;
    w_cmd       = CMD_HOLD;
    w_row_start = 1'b0;
    w_to_finish = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_r_nxt     = '0;
          w_c_nxt     = '0;
          w_ri_nxt    = ROW_TOP;
          w_cmd       = CMD_INIT;
          w_row_start = 1'b1;
        end
      end
      VALID: begin
        if (r_row_idx != ROW_BOT) begin
          w_ri_nxt    = r_row_idx + 2'd1;
          w_cmd       = CMD_INC;
          w_row_start = 1'b1;
        end else if ((r_out_r == R_LAST) && (r_out_c == C_LAST)) begin
          w_r_nxt     = '0;
          w_c_nxt     = '0;
          w_ri_nxt    = ROW_TOP;
          w_to_finish = 1'b1;
        end else begin
          w_ri_nxt    = ROW_TOP;
          w_row_start = 1'b1;
          if (r_out_c == C_LAST) begin
            w_c_nxt = '0;
            w_r_nxt = r_out_r + RW'(1);
            w_cmd   = CMD_DEC1;
          end else begin
            w_c_nxt = r_out_c + CW'(1);
            w_cmd   = CMD_DEC2;
          end
        end
      end
      default: ;
    endcase
  end

  // Next state; a row start skips ISSUE entirely when the source row is padding
  always_comb begin
    w_state_nxt = r_state;
    w_tap_nxt   = r_tap;
    unique case (r_state)
      IDLE: ;
      ISSUE: begin
        unique case (r_tap)
          TAP_L: w_tap_nxt = TAP_C;
          TAP_C: begin
            if (w_right_ok) begin
              w_tap_nxt = TAP_R;
            end else begin
              w_state_nxt = DRAIN;
            end
          end
          default: w_state_nxt = DRAIN;
        endcase
      end
      DRAIN:  w_state_nxt = VALID;
      VALID: begin
        if (w_to_finish) begin
          w_state_nxt = FINISH;
        end
      end
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_row_start) begin
      if (w_row_ok) begin
        w_state_nxt = ISSUE;
        w_tap_nxt   = w_left_ok ? TAP_L : TAP_C;
      end else begin
        w_state_nxt = VALID;
      end
    end
  end

  conv_pad_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .CW     (CW)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .i_cmd      (w_cmd),
    .i_issue    (w_state_nxt == ISSUE),
    .i_tap      (w_tap_nxt),
    .i_col      (w_c_nxt),
    .o_row_ok   (w_row_ok),
    .o_left_ok  (w_left_ok),
    .o_right_ok (w_right_ok),
    .o_rd_addr  (rd_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tap       <= TAP_L;
      r_out_r     <= '0;
      r_out_c     <= '0;
      r_row_idx   <= ROW_TOP;
      r_rd_en     <= 1'b0;
      r_sel       <= SEL_CLEAR;
      r_row_valid <= 1'b0;
      r_win_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tap       <= w_tap_nxt;
      r_out_r     <= w_r_nxt;
      r_out_c     <= w_c_nxt;
      r_row_idx   <= w_ri_nxt;
      r_rd_en     <= (w_state_nxt == ISSUE);
      // One-cycle lag matches the RAM latency, so sel lines up with pix
      r_sel       <= r_rd_en ? tap_sel(r_tap) : SEL_CLEAR;
      r_row_valid <= (w_state_nxt == VALID);
      r_win_last  <= (w_state_nxt == VALID) && (w_ri_nxt == ROW_BOT) &&
                     (w_r_nxt == R_LAST) && (w_c_nxt == C_LAST);
      r_busy      <= (w_state_nxt == ISSUE) || (w_state_nxt == DRAIN) ||
                     (w_state_nxt == VALID);
      r_done      <= (w_state_nxt == FINISH);
    end
  end

`ifdef CONV_PAD_PERF_CNT_EN
  logic [15:0] r_cycle_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_cycle_cnt <= '0;
    end else if (r_busy && (r_cycle_cnt != 16'hFFFF)) begin
      r_cycle_cnt <= r_cycle_cnt + 16'd1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
`endif

  assign rd_en     = r_rd_en;
  assign sel       = r_sel;
  assign row_valid = r_row_valid;
  assign row_idx   = r_row_idx;
  assign out_r     = r_out_r;
  assign out_c     = r_out_c;
  assign win_last  = r_win_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_conv_pad_sequencer.sv
// ----------------------------------------------------------------------------
// tb_conv_pad_sequencer: 4x3 image scans with RAM and row-buffer models, a
// scoreboard of expected reads/rows, plus start-while-busy and mid-row reset.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_conv_pad_sequencer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [1:0]    sel;
  logic          row_valid;
  logic [1:0]    row_idx;
  logic [1:0]    out_r;
  logic [1:0]    out_c;
  logic          win_last;
  logic          busy;
  logic          done;
`ifdef CONV_PAD_PERF_CNT_EN
  logic [15:0]   cycle_cnt;
`endif

  always #5 clk = ~clk;

  conv_pad_sequencer #(
    .IMG_W  (W),
    .IMG_H  (H),
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .sel       (sel),
    .row_valid (row_valid),
    .row_idx   (row_idx),
    .out_r     (out_r),
    .out_c     (out_c),
    .win_last  (win_last),
    .busy      (busy),
    .done      (done)
`ifdef CONV_PAD_PERF_CNT_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  typedef struct {
    logic [1:0]  ri;
    logic [1:0]  r;
    logic [1:0]  c;
    logic        last;
    logic [23:0] val;
  } row_t;

  row_t          q_row[$];
  logic [AW-1:0] q_addr[$];

  int errs    = 0;
  int checks  = 0;
  int cyc     = 0;
  int n_rv    = 0;
  int n_last  = 0;
  int t_start = -1;
  int t_first11 = -1;

  logic [7:0]  pix;
  logic [23:0] rowbuf;
  logic [23:0] hand_corner [3] = '{24'h000000, 24'h001011, 24'h001415};
  logic [23:0] hand_inner  [3] = '{24'h101112, 24'h141516, 24'h18191A};

  function automatic logic [7:0] img(input int a);
    return 8'(a + 16);
  endfunction

  // Synchronous image RAM and the padded row buffer it feeds
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) pix <= img(int'(rd_addr));
    case (sel)
      2'b00:   rowbuf[23:16] <= pix;
      2'b10:   rowbuf[15:8]  <= pix;
      2'b01:   rowbuf[7:0]   <= pix;
      default: rowbuf        <= 24'h0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic gen_scan();
    row_t e;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        for (int ri = 0; ri < 3; ri++) begin
          int sr;
          sr     = r + ri - 1;
          e.ri   = 2'(ri);
          e.r    = 2'(r);
          e.c    = 2'(c);
          e.last = (r == H - 1) && (c == W - 1) && (ri == 2);
          e.val  = 24'h0;
          if (sr >= 0 && sr < H) begin
            if (c > 0) begin
              q_addr.push_back(AW'(sr * W + c - 1));
              e.val[23:16] = img(sr * W + c - 1);
            end
            q_addr.push_back(AW'(sr * W + c));
            e.val[15:8] = img(sr * W + c);
            if (c < W - 1) begin
              q_addr.push_back(AW'(sr * W + c + 1));
              e.val[7:0] = img(sr * W + c + 1);
            end
          end
          q_row.push_back(e);
        end
      end
    end
  endtask

  task automatic monitor();
    row_t          e;
    logic [AW-1:0] ea;
    forever begin
      @(negedge clk);
      if (rd_en) begin
        if (out_r == 2'd1 && out_c == 2'd1 && row_idx == 2'd0 && t_first11 < 0)
          t_first11 = cyc;
        chk("rd_expected", 32'(q_addr.size() != 0), 32'd1);
        if (q_addr.size() != 0) begin
          ea = q_addr.pop_front();
          chk("rd_addr", 32'(rd_addr), 32'(ea));
        end
      end
      if (row_valid) begin
        n_rv++;
        if (win_last) n_last++;
        chk("row_expected", 32'(q_row.size() != 0), 32'd1);
        if (q_row.size() != 0) begin
          e = q_row.pop_front();
          chk("row_idx", 32'(row_idx), 32'(e.ri));
          chk("out_r", 32'(out_r), 32'(e.r));
          chk("out_c", 32'(out_c), 32'(e.c));
          chk("win_last", 32'(win_last), 32'(e.last));
          chk("row_data", 32'(rowbuf), 32'(e.val));
        end
        if (out_r == 2'd0 && out_c == 2'd0 && row_idx != 2'd3)
          chk("hand_corner", 32'(rowbuf), 32'(hand_corner[row_idx]));
        if (out_r == 2'd1 && out_c == 2'd1 && row_idx != 2'd3)
          chk("hand_inner", 32'(rowbuf), 32'(hand_inner[row_idx]));
        if (out_r == 2'd0 && out_c == 2'd0 && row_idx == 2'd2 && t_start >= 0)
          chk("corner_cycles", 32'(cyc - t_start), 32'd9);
        if (out_r == 2'd1 && out_c == 2'd1 && row_idx == 2'd2 && t_first11 >= 0)
          chk("inner_cycles", 32'(cyc - t_first11 + 1), 32'd15);
      end
    end
  endtask

  task automatic run_scan(input int stray);
    int rv0, last0, nbusy, k;
    logic prev_last;
    gen_scan();
    rv0 = n_rv;
    last0 = n_last;
    t_first11 = -1;
    start = 1'b1;
    t_start = cyc;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0;
    k = 1;
    prev_last = 1'b0;
    while (!done && k < 2000) begin
      if (busy) nbusy++;
      prev_last = row_valid && win_last;
      start = (k == stray);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("done_after_last", 32'(prev_last), 32'd1);
    chk("busy_cycles", 32'(nbusy), 32'd134);
    chk("row_valid_count", 32'(n_rv - rv0), 32'd36);
    chk("win_last_count", 32'(n_last - last0), 32'd1);
    chk("reads_left", 32'(q_addr.size()), 32'd0);
    chk("rows_left", 32'(q_row.size()), 32'd0);
`ifdef CONV_PAD_PERF_CNT_EN
    chk("cycle_cnt", 32'(cycle_cnt), 32'(nbusy));
`endif
    @(negedge clk);
    chk("done_pulse_width", 32'(done), 32'd0);
    chk("idle_sel", 32'(sel), 32'd3);
    chk("idle_pos", 32'({out_r, out_c, row_idx}), 32'd0);
`ifdef CONV_PAD_PERF_CNT_EN
    repeat (3) @(negedge clk);
    chk("cycle_cnt_hold", 32'(cycle_cnt), 32'(nbusy));
`endif
  endtask

  initial begin
    int k;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sel", 32'(sel), 32'd3);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_flags", 32'({row_valid, busy, done, win_last}), 32'd0);
    chk("rst_pos", 32'({out_r, out_c, row_idx}), 32'd0);
    rst = 1'b0;
    fork
      monitor();
    join_none
    @(negedge clk);

    run_scan(-1);
    repeat (2) @(negedge clk);
    run_scan(20);
    repeat (2) @(negedge clk);

    // Reset in the middle of a row while the centre tap is being written
    gen_scan();
    start = 1'b1;
    t_start = cyc;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (sel != 2'b10 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("sel_centre_seen", 32'(sel), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_sel", 32'(sel), 32'd3);
    chk("midrst_rd_en", 32'(rd_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_pos", 32'({out_r, out_c, row_idx, row_valid, done}), 32'd0);
    q_addr.delete();
    q_row.delete();
    repeat (2) @(negedge clk);
    run_scan(-1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/conv_pad_sequencer.md
Name: conv_pad_sequencer

Overview:
- Sequences the 3-tap padded pixel row buffer for a 3x3 zero-padded convolution scan.
- Walks every output position (r,c) in raster order and fetches image pixels from a synchronous image RAM.
- Drives the buffer's 2-bit slot select so each in-bounds tap lands in the correct byte. Out-of-bounds taps and rows stay zero through the buffer's clear code.
- Emits row_valid three times per window (top, middle, bottom) so the downstream MAC samples the buffer's 24-bit output.

Parameters:
IMG_W, 28, image width in pixels (>=2)
IMG_H, 28, image height in pixels (>=2)
ADDR_W, 10, image RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a full-image scan when idle
rd_en  out  1  image RAM read strobe
rd_addr  out  ADDR_W  pixel address r*IMG_W+c; data returns on pix one cycle later
sel  out  2  buffer slot select: 00 = left tap into [23:16], 10 = centre tap into [15:8], 01 = right tap into [7:0], 11 = clear
row_valid  out  1  buffer output holds a complete padded row this cycle
row_idx  out  2  0 = top (r-1), 1 = middle (r), 2 = bottom (r+1)
out_r  out  $clog2(IMG_H)  current output row
out_c  out  $clog2(IMG_W)  current output column
win_last  out  1  with row_valid: bottom row of the final window (IMG_H-1, IMG_W-1)
busy  out  1  scan in progress
done  out  1  one-cycle pulse in the cycle after the final row_valid

Behaviour:
- Reset or idle: sel=11, rd_en=0, row_valid=0, busy=0, done=0, out_r=out_c=0, row_idx=0, win_last=0. All outputs are registered.
- States:
  - IDLE: waits for start; start sets busy=1, out_r=out_c=0, row_idx=0, then goes to ISSUE.
  - ISSUE: handles the current source row sr = out_r+row_idx-1.
    - If sr is out of range (-1 or IMG_H), go straight to VALID; no reads are issued.
    - Otherwise issue one read per in-bounds tap, one per cycle, in order L (c-1), C, R (c+1).
    - L is skipped when c=0; R is skipped when c=IMG_W-1.
  - DRAIN: one cycle to load the last returned tap.
  - VALID: row_valid=1 for one cycle.
- Select timing:
  - sel lags its read by exactly one cycle (RAM latency 1), so sel is valid in the cycle pix holds that tap.
  - In every cycle with no tap write, including VALID and IDLE, sel=11.
  - The buffer therefore starts each row cleared, and skipped taps read as zero.
  - The consumer samples the buffer on the edge ending the VALID cycle, which is the pre-clear value.
- Row cycle counts:
  - In-bounds row with k taps: k+2 cycles (k issue, 1 drain, 1 valid).
  - Out-of-bounds row: 1 cycle.
  - Interior window: 15 cycles; corner window (0,0): 1+4+4 = 9 cycles.
- After VALID:
  - row_idx<2: increment row_idx, back to ISSUE.
  - row_idx=2 and not the last window: row_idx=0, advance out_c; when out_c wraps to 0, advance out_r; back to ISSUE.
  - row_idx=2 on the last window: go to FINISH.
- FINISH: done=1 and busy=0 for one cycle, then IDLE.
- Addressing: no multiplier. Keep a registered base address = (sr)*IMG_W, updated by +/-IMG_W as rows change, and add a tap offset of -1/0/+1.
- start while busy: ignored.
- rst mid-scan: the next cycle is IDLE with reset outputs. The buffer is cleared within one cycle because sel=11.

Optional Feature:
- Macro: CONV_PAD_PERF_CNT_EN.
- When defined: adds output cycle_cnt[15:0], which counts busy cycles, is cleared on an accepted start, saturates at 0xFFFF, and holds its value after done.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package conv_pkg holds:
  - sel encodings SEL_LEFT=2'b00, SEL_RIGHT=2'b01, SEL_CENTRE=2'b10, SEL_CLEAR=2'b11;
  - the FSM state enum (IDLE, ISSUE, DRAIN, VALID, FINISH);
  - row_idx constants ROW_TOP/ROW_MID/ROW_BOT.
- One sub-module, conv_pad_addr_gen, owns the base register, tap offset and in-bounds flags. The FSM stays in the top level.

Test Plan:
- IMG_W=4, IMG_H=3, start pulse, then window (0,0): row 0 = 1 cycle of VALID, no rd_en. Row 1 reads addr 0,1 and sel is 10,01 one cycle later. Row 2 reads 4,5. Sampled buffer rows are 0x000000, 0x00P0P1, 0x00P4P5.
- Interior window (1,1) on a 4x3 image: reads 0,1,2 / 4,5,6 / 8,9,10; sels 00,10,01 each row; 15 cycles from the first read to the third row_valid.
- Full 4x3 scan: exactly 36 row_valid pulses. win_last is asserted only on the 36th, with out_r=2, out_c=3. done pulses the next cycle and busy falls.
- start asserted on cycle 20 of a scan: no restart; pulse count and done timing unchanged.
- rst asserted mid-row while sel=10: next cycle sel=11, rd_en=0, busy=0. A fresh start reproduces the first scenario exactly.
- With CONV_PAD_PERF_CNT_EN, full 4x3 scan: cycle_cnt equals the busy-high cycle count measured by the bench and holds after done.
